// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the register-file operation sequencer.
// Holds the default data/address widths, op encodings and the FSM state type.
package rf_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ADDR  = 3;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_LOADI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_A  = 2'd1,
        ST_RD_B  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational ALU for the sequencer.
// Ports: a, b (operands), op (encoding) -> result, carry (carry/borrow).
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // top bit of a zero-extended subtraction is the unsigned borrow
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = a & b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: runs one ADD/SUB/AND/LOADI command against an external
// register file. Ports: cmd_* handshake/fields in, rf_* read/write port, done, carry.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       op,
    input  logic [ADDR-1:0]  rs1,
    input  logic [ADDR-1:0]  rs2,
    input  logic [ADDR-1:0]  rd,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic [ADDR-1:0]  rf_ra,
    output logic [ADDR-1:0]  rf_wa,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             rf_we,
    output logic             done,
    output logic             carry
);

    state_e           state;
    logic [1:0]       op_q;
    logic [ADDR-1:0]  rs1_q;
    logic [ADDR-1:0]  rs2_q;
    logic [ADDR-1:0]  rd_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    rf_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (rf_rdata),
        .op     (op_q),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= op;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        rd_q  <= rd;
                        imm_q <= imm;
                        state <= (op == OP_LOADI) ? ST_WRITE : ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    a_q   <= rf_rdata;
                    state <= ST_RD_B;
                end
                ST_RD_B: begin
                    res_q   <= alu_res;
                    carry_q <= alu_carry;
                    state   <= ST_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_ra = '0;
        if (state == ST_RD_A) rf_ra = rs1_q;
        if (state == ST_RD_B) rf_ra = rs2_q;
    end

    assign cmd_ready = (state == ST_IDLE);
    assign rf_we     = (state == ST_WRITE);
    assign done      = (state == ST_WRITE);
    assign rf_wa     = rd_q;
    // LOADI bypasses the result register so its write never disturbs it
    assign rf_wdata  = (rf_we && op_q == OP_LOADI) ? imm_q : res_q;
    assign carry     = carry_q;

endmodule

// File: doc/rf_op_sequencer.md
RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the data width (matches register-file word).
REQ-002 The block SHALL have parameter ADDR, default 3, the register address width (8 registers).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low: CLK  in  1  rising-edge clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 CMD_VALID  in  1  command offered.
REQ-006 CMD_READY  out  1  sequencer can accept a command.
REQ-007 OP  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 LOADI.
REQ-008 RS1, RS2, RD  in  ADDR each  source A, source B, destination register.
REQ-009 IMM  in  WIDTH  immediate for LOADI.
REQ-010 RF_RDATA  in  WIDTH  combinational read data from the register file (read address RF_RA).
REQ-011 RF_RA  out  ADDR  register-file read address.
REQ-012 RF_WA  out  ADDR  register-file write address.
REQ-013 RF_WDATA  out  WIDTH  register-file write data.
REQ-014 RF_WE  out  1  register-file write enable.
REQ-015 DONE  out  1  one-cycle pulse, high in the write cycle.
REQ-016 CARRY  out  1  registered carry/borrow flag of the last ADD/SUB.

Function
REQ-017 The FSM SHALL have four states: IDLE, RD_A, RD_B, WRITE.
REQ-018 CMD_READY SHALL be 1 exactly when the state is IDLE; a command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1.
REQ-019 On acceptance, OP, RS1, RS2, RD and IMM SHALL be captured; the next state is RD_A for ADD/SUB/AND and WRITE for LOADI.
REQ-020 RD_A: RF_RA=captured RS1; RF_RDATA SHALL be latched into operand register A at the end of the cycle; the next state is RD_B.
REQ-021 RD_B: RF_RA=captured RS2; the result SHALL be computed from A and RF_RDATA and registered, with CARRY updated; the next state is WRITE.
REQ-022 WRITE: RF_WE=1, RF_WA=captured RD, RF_WDATA=result (IMM for LOADI), DONE=1; the next state is IDLE.
REQ-023 Latency: ALU op accepted at edge N writes the register at edge N+3; LOADI writes at edge N+1; the next command is accepted no earlier than the edge after WRITE.
REQ-024 ADD: result = (A+B) mod 2^WIDTH, CARRY = bit WIDTH of the sum.
REQ-025 SUB: result = (A-B) mod 2^WIDTH, CARRY = 1 iff A<B (unsigned borrow).
REQ-026 AND: result = A&B, CARRY = 0; LOADI SHALL leave CARRY unchanged.
REQ-027 Outside WRITE: RF_WE=0, DONE=0, RF_WA=captured RD, RF_WDATA=result register; RF_RA=0 in IDLE and WRITE.
REQ-028 RS1=RS2=RD aliasing SHALL be legal; operands SHALL be the pre-write values.
REQ-029 CMD_VALID while not IDLE SHALL be ignored; the upstream source holds its command until it is accepted.

Reset
REQ-030 RST_N=0 SHALL force IDLE, A=0, result=0, CARRY=0, and all captured fields 0 immediately, independent of CLK.
REQ-031 During reset: CMD_READY=1, RF_WE=0, DONE=0, RF_RA=0, RF_WA=0, RF_WDATA=0.
REQ-032 Reset asserted in RD_A, RD_B or WRITE SHALL abort the command with no register-file write.

Structure
REQ-033 The shared package rf_seq_pkg SHALL hold the OP encodings, the FSM state enum, and the WIDTH/ADDR defaults.
REQ-034 The ALU SHALL be one combinational sub-module, rf_seq_alu (A, B, OP -> result, carry).

Verification
REQ-035 LOADI RD=3 IMM=0xA -> RF_WE=1, RF_WA=3, RF_WDATA=0xA, DONE=1 one cycle after acceptance.
REQ-036 R1=0x9, R2=0x8, ADD RD=4 -> write R4=0x1 three cycles after acceptance, CARRY=1.
REQ-037 SUB R1=0x3, R2=0x5 -> result 0xE, CARRY=1; then AND 0xC&0x6 -> 0x4, CARRY=0.
REQ-038 ADD RS1=RS2=RD=2 with R2=0x5 -> R2=0xA written; CMD_READY is 0 for 3 cycles after acceptance.
REQ-039 RST_N pulsed low during RD_B -> no RF_WE, state IDLE, CARRY=0, CMD_READY=1.
REQ-040 Back-to-back CMD_VALID held high -> second command accepted only on the edge after the first WRITE, with no lost or duplicated write.
